// File: rtl/ovc_corner_pkg.sv
// Shared definitions for the corner DMA: entry/header layout and FSM states.
// Field positions live here so the packer and any consumer agree on them.
package ovc_corner_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_FLUSH,
      S_HEADER,
      S_DONE
   } dma_state_t;

   localparam int ENT_VALID   = 31;
   localparam int ENT_X_LSB   = 18;
   localparam int ENT_Y_LSB   = 8;
   localparam int ENT_S_LSB   = 0;

   localparam int HDR_SEQ_LSB = 96;
   localparam int HDR_OVF_BIT = 80;
   localparam int HDR_CNT_LSB = 64;

   function automatic logic [31:0] pack_entry(
      input logic [10:0] x,
      input logic [9:0]  y,
      input logic [7:0]  s
   );
      logic [31:0] e;
      e = '0;
      e[ENT_VALID] = 1'b1;
      e[ENT_X_LSB +: 11] = x;
      e[ENT_Y_LSB +: 10] = y;
      e[ENT_S_LSB +: 8]  = s;
      return e;
   endfunction

   function automatic logic [127:0] header_word(
      input logic [31:0] seq,
      input logic        ovf,
      input logic [15:0] cnt
   );
      logic [127:0] h;
      h = '0;
      h[HDR_SEQ_LSB +: 32] = seq;
      h[HDR_OVF_BIT]       = ovf;
      h[HDR_CNT_LSB +: 16] = cnt;
      return h;
   endfunction

endpackage

// File: rtl/corner_dma_fifo.sv
// Synchronous first-word-fall-through FIFO with level and full/empty flags.
// A push while full is accepted only if a pop frees a slot that same cycle.
module corner_dma_fifo #(
   parameter int DEPTH = 64,
   parameter int W     = 128,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         c,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic [AW:0]  level,
   output logic         full,
   output logic         empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level == '0);
   assign full    = (level == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rptr];

   always_ff @(posedge c) begin
      if (do_push) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge c) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + AW'(1);
         end
         if (do_pop) begin
            rptr <= rptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            level <= level + (AW+1)'(1);
         end else if (do_pop && !do_push) begin
            level <= level - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/corner_dma.sv
// Corner DMA: packs detector corners four per word, bursts them over
// Avalon-MM after the frame header slot, then writes the header and irqs.
module corner_dma
   import ovc_corner_pkg::*;
#(
   parameter int FIFO_DEPTH = 64,
   parameter int BURST_MAX  = 16
) (
   input  logic         c,
   input  logic         rst_n,
   input  logic         en,
   input  logic [22:0]  base_addr,
   input  logic [15:0]  max_corners,
   input  logic         corner_valid,
   input  logic [10:0]  corner_x,
   input  logic [9:0]   corner_y,
   input  logic [7:0]   corner_score,
   input  logic         frame_start,
   input  logic         frame_end,
   input  logic         txs_waitrequest,
   output logic         txs_write,
   output logic [22:0]  txs_address,
   output logic [5:0]   txs_burstcount,
   output logic [127:0] txs_writedata,
   output logic         irq,
   output logic         overflow,
   output logic [15:0]  corner_count
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LW-1:0] BMAX_L = LW'(BURST_MAX);

   dma_state_t     state;
   dma_state_t     state_nx;

   logic [LW-1:0]  level;
   logic           full;
   logic           empty;
   logic [127:0]   fifo_rdata;
   logic           fifo_pop;

   logic [127:0]   pack_buf;
   logic [127:0]   buf_nx;
   logic [127:0]   push_word;
   logic [1:0]     slot;
   logic           push_q;

   logic [22:0]    word_idx;
   logic [5:0]     beats_left;
   logic [5:0]     burst_len;
   logic           hdr_mode;
   logic [31:0]    frame_seq;

   logic           in_collect;
   logic           room;
   logic           accept;
   logic           reject_full;
   logic           beat_ok;
   logic           push_drop;
   logic           burst_start;
   logic           frame_go;

   assign in_collect  = (state == S_COLLECT);
   assign room        = (corner_count < max_corners);
   assign accept      = in_collect & corner_valid & room & ~full;
   assign reject_full = in_collect & corner_valid & room & full;
   assign beat_ok     = txs_write & ~txs_waitrequest;
   assign fifo_pop    = beat_ok & ~hdr_mode;
   assign push_drop   = push_q & full & ~fifo_pop;
   assign frame_go    = (state == S_IDLE) & frame_start & en;

   assign burst_start = (in_collect | (state == S_FLUSH)) & ~txs_write &
                        ((level >= BMAX_L) |
                         ((state == S_FLUSH) & (level != '0)));
   assign burst_len   = (level >= BMAX_L) ? 6'(BURST_MAX) : 6'(level);

   assign irq = (state == S_DONE);
   assign txs_writedata = hdr_mode  ? header_word(frame_seq, overflow,
                                                  corner_count) :
                          txs_write ? fifo_rdata : '0;

   always_comb begin
      buf_nx = pack_buf;
      if (accept) begin
         buf_nx[{slot, 5'b0} +: 32] = pack_entry(corner_x, corner_y,
                                                 corner_score);
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (frame_go) state_nx = S_COLLECT;
         S_COLLECT: if (frame_end) state_nx = S_FLUSH;
         S_FLUSH:   if (empty && !txs_write && !push_q) state_nx = S_HEADER;
         S_HEADER:  if (hdr_mode && beat_ok) state_nx = S_DONE;
         S_DONE:    state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge c) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Packer: a completed word is pushed the cycle after its last corner.
   always_ff @(posedge c) begin
      if (!rst_n) begin
         pack_buf     <= '0;
         push_word    <= '0;
         slot         <= '0;
         push_q       <= 1'b0;
         corner_count <= '0;
         overflow     <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (frame_go) begin
            pack_buf     <= '0;
            slot         <= '0;
            corner_count <= '0;
            overflow     <= 1'b0;
         end
         if (accept) begin
            corner_count <= corner_count + 16'd1;
         end
         if (reject_full || push_drop) begin
            overflow <= 1'b1;
         end
         if (in_collect) begin
            if ((accept && slot == 2'd3) ||
                (frame_end && (accept || slot != 2'd0))) begin
               push_word <= buf_nx;
               push_q    <= 1'b1;
               pack_buf  <= '0;
               slot      <= '0;
            end else if (accept) begin
               pack_buf <= buf_nx;
               slot     <= slot + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge c) begin
      if (!rst_n) begin
         txs_write      <= 1'b0;
         txs_address    <= '0;
         txs_burstcount <= '0;
         beats_left     <= '0;
         hdr_mode       <= 1'b0;
         word_idx       <= '0;
         frame_seq      <= '0;
      end else begin
         if (frame_go) begin
            word_idx <= '0;
         end
         if (burst_start) begin
            txs_write      <= 1'b1;
            txs_address    <= base_addr + 23'd1 + word_idx;
            txs_burstcount <= burst_len;
            beats_left     <= burst_len;
            word_idx       <= word_idx + {17'b0, burst_len};
         end else if (state == S_HEADER && !txs_write && !hdr_mode) begin
            txs_write      <= 1'b1;
            txs_address    <= base_addr;
            txs_burstcount <= 6'd1;
            beats_left     <= 6'd1;
            hdr_mode       <= 1'b1;
         end else if (beat_ok) begin
            beats_left <= beats_left - 6'd1;
            if (beats_left == 6'd1) begin
               txs_write <= 1'b0;
               hdr_mode  <= 1'b0;
            end
         end
         if (state == S_DONE) begin
            frame_seq <= frame_seq + 32'd1;
         end
      end
   end

   corner_dma_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (128)
   ) u_fifo (
      .c     (c),
      .rst_n (rst_n),
      .push  (push_q),
      .wdata (push_word),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .level (level),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_corner_dma.sv
// Self-checking bench for corner_dma: a word-level model of the frame
// output plus an Avalon-MM bus monitor that checks every accepted beat.
module tb_corner_dma;

   localparam int FD = 64;
   localparam int BM = 16;

   logic         c = 1'b0;
   logic         rst_n;
   logic         en;
   logic [22:0]  base_addr;
   logic [15:0]  max_corners;
   logic         corner_valid;
   logic [10:0]  corner_x;
   logic [9:0]   corner_y;
   logic [7:0]   corner_score;
   logic         frame_start;
   logic         frame_end;
   logic         txs_waitrequest;
   logic         txs_write;
   logic [22:0]  txs_address;
   logic [5:0]   txs_burstcount;
   logic [127:0] txs_writedata;
   logic         irq;
   logic         overflow;
   logic [15:0]  corner_count;

   always #4 c = ~c;

   corner_dma #(
      .FIFO_DEPTH (FD),
      .BURST_MAX  (BM)
   ) dut (
      .c               (c),
      .rst_n           (rst_n),
      .en              (en),
      .base_addr       (base_addr),
      .max_corners     (max_corners),
      .corner_valid    (corner_valid),
      .corner_x        (corner_x),
      .corner_y        (corner_y),
      .corner_score    (corner_score),
      .frame_start     (frame_start),
      .frame_end       (frame_end),
      .txs_waitrequest (txs_waitrequest),
      .txs_write       (txs_write),
      .txs_address     (txs_address),
      .txs_burstcount  (txs_burstcount),
      .txs_writedata   (txs_writedata),
      .irq             (irq),
      .overflow        (overflow),
      .corner_count    (corner_count)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Model state
   logic [127:0] exp_words[$];
   logic [127:0] obs_words[$];
   int           bl_q[$];
   int           ad_q[$];
   logic [127:0] exp_hdr;
   int           hdr_chk_mode;
   int           data_idx;
   int           hdr_seen;
   int           irq_cnt;
   bit           mon_en;
   int           wr_mode;
   int           exp_seq;

   function automatic logic [10:0] cx(int i);
      return 11'((16 * i + 3) % 2048);
   endfunction
   function automatic logic [9:0] cy(int i);
      return 10'((i + 7) % 1024);
   endfunction
   function automatic logic [7:0] cs(int i);
      return 8'((5 * i + 1) % 256);
   endfunction
   function automatic logic [31:0] ent(int i);
      return 32'h8000_0000 + (32'(cx(i)) << 18) + (32'(cy(i)) << 8)
             + 32'(cs(i));
   endfunction

   task automatic build_model(input int n, input int maxc);
      int nacc;
      logic [127:0] w;
      nacc = (n < maxc) ? n : maxc;
      exp_words.delete();
      w = '0;
      for (int i = 0; i < nacc; i++) begin
         w = w | (128'(ent(i)) << (32 * (i % 4)));
         if ((i % 4) == 3 || i == nacc - 1) begin
            exp_words.push_back(w);
            w = '0;
         end
      end
      exp_hdr = {32'(exp_seq), 15'b0, 1'b0, 16'(nacc), 64'b0};
   endtask

   // Waitrequest pattern: 0 none, 1 random, 2 held high
   always @(posedge c) begin
      #1;
      case (wr_mode)
         1:       txs_waitrequest = 1'($urandom_range(0, 1));
         2:       txs_waitrequest = 1'b1;
         default: txs_waitrequest = 1'b0;
      endcase
   end

   bit           in_b;
   int           b_rem;
   logic [22:0]  b_addr;
   logic [5:0]   b_cnt;
   bit           b_hdr;
   bit           p_stall;
   logic [127:0] p_data;

   always @(negedge c) begin
      if (!mon_en) begin
         in_b    = 1'b0;
         p_stall = 1'b0;
      end else begin
         if (irq) irq_cnt++;
         if (p_stall) begin
            chk("stall_write", txs_write, 1'b1);
            chk("stall_data", txs_writedata, p_data);
            chk("stall_addr", txs_address, b_addr);
            chk("stall_cnt", txs_burstcount, b_cnt);
         end
         if (txs_write) begin
            if (!in_b) begin
               in_b   = 1'b1;
               b_addr = txs_address;
               b_cnt  = txs_burstcount;
               b_rem  = int'(b_cnt);
               b_hdr  = (txs_address == base_addr) && (b_cnt == 6'd1);
               bl_q.push_back(int'(b_cnt));
               ad_q.push_back(int'(b_addr));
               if (!b_hdr) begin
                  chk("burst_addr", txs_address,
                      base_addr + 23'd1 + 23'(data_idx));
                  chk("burst_len_ok",
                      (b_cnt >= 6'd1) && (int'(b_cnt) <= BM), 1'b1);
               end
            end else begin
               chk("addr_hold", txs_address, b_addr);
            end
            if (!txs_waitrequest) begin
               if (b_hdr) begin
                  hdr_seen++;
                  if (hdr_chk_mode == 0) begin
                     chk("header", txs_writedata, exp_hdr);
                  end else begin
                     chk("hdr_ovf", txs_writedata[80], 1'b1);
                     chk("hdr_seq", txs_writedata[127:96], exp_hdr[127:96]);
                  end
               end else begin
                  obs_words.push_back(txs_writedata);
                  if (data_idx < exp_words.size())
                     chk("beat_data", txs_writedata, exp_words[data_idx]);
                  else
                     chk("beat_extra", data_idx < exp_words.size(), 1'b1);
                  data_idx++;
               end
               b_rem--;
               if (b_rem == 0) in_b = 1'b0;
            end
         end else if (in_b) begin
            chk("idle_in_burst", txs_write, 1'b1);
            in_b = 1'b0;
         end
         p_stall = txs_write && txs_waitrequest;
         p_data  = txs_writedata;
      end
   end

   task automatic run_frame(input int n, input int maxc, input int wm,
                            input int hmode, input int exp_beats);
      bit got;
      max_corners = 16'(maxc);
      build_model(n, maxc);
      data_idx = 0;
      obs_words.delete();
      bl_q.delete();
      ad_q.delete();
      hdr_seen = 0;
      irq_cnt = 0;
      hdr_chk_mode = hmode;
      wr_mode = wm;
      @(posedge c); #1 frame_start = 1'b1;
      @(posedge c); #1 frame_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         corner_valid = 1'b1;
         corner_x     = cx(i);
         corner_y     = cy(i);
         corner_score = cs(i);
         @(posedge c); #1;
      end
      corner_valid = 1'b0;
      frame_end = 1'b1;
      @(posedge c); #1 frame_end = 1'b0;
      if (wm == 2) begin
         repeat (4) @(posedge c);
         wr_mode = 0;
      end
      got = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge c);
         if (irq) begin
            got = 1'b1;
            break;
         end
      end
      chk("irq_seen", got, 1'b1);
      @(posedge c); @(posedge c); #1;
      chk("irq_pulses", irq_cnt, 1);
      chk("hdr_beats", hdr_seen, 1);
      chk("data_beats", data_idx,
          (exp_beats < 0) ? exp_words.size() : exp_beats);
      exp_seq++;
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      en = 1'b1;
      base_addr = 23'h100;
      max_corners = 16'd1000;
      corner_valid = 1'b0;
      corner_x = '0;
      corner_y = '0;
      corner_score = '0;
      frame_start = 1'b0;
      frame_end = 1'b0;
      txs_waitrequest = 1'b0;
      wr_mode = 0;
      mon_en = 1'b0;
      exp_seq = 0;
      hdr_chk_mode = 0;
      repeat (3) @(posedge c);
      #1;
      chk("rst_write", txs_write, 1'b0);
      chk("rst_addr", txs_address, 23'h0);
      chk("rst_bcnt", txs_burstcount, 6'h0);
      chk("rst_data", txs_writedata, 128'h0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_count", corner_count, 16'h0);
      rst_n = 1'b1;
      mon_en = 1'b1;

      // 8 corners: one 2-beat burst then the header
      run_frame(8, 1000, 0, 0, -1);
      chk("a_nbursts", bl_q.size(), 2);
      chk("a_len0", bl_q[0], 2);
      chk("a_addr0", ad_q[0], 32'h101);
      chk("a_len1", bl_q[1], 1);
      chk("a_addr1", ad_q[1], 32'h100);
      chk("a_count", corner_count, 16'd8);
      chk("a_ovf", overflow, 1'b0);

      // 5 corners: second word zero-padded
      run_frame(5, 1000, 0, 0, -1);
      chk("b_w1_hi", obs_words[1][127:32], 96'h0);
      chk("b_w1_lo", obs_words[1][31:0], 32'h810C0B15);

      // 70 corners: bursts of 16 and 2
      run_frame(70, 1000, 0, 0, -1);
      chk("c_nbursts", bl_q.size(), 3);
      chk("c_len0", bl_q[0], 16);
      chk("c_addr0", ad_q[0], 32'h101);
      chk("c_len1", bl_q[1], 2);
      chk("c_addr1", ad_q[1], 32'h111);
      chk("c_count", corner_count, 16'd70);

      // random stalls
      run_frame(40, 1000, 1, 0, -1);
      chk("d_count", corner_count, 16'd40);

      // corner limit of 3
      run_frame(10, 3, 0, 0, 1);
      chk("e_count", corner_count, 16'd3);
      chk("e_ovf", overflow, 1'b0);

      // bus stalled while 300 corners arrive
      run_frame(300, 1000, 2, 1, FD);
      chk("f_ovf", overflow, 1'b1);

      // reset in the middle of a burst
      max_corners = 16'd1000;
      wr_mode = 2;
      @(posedge c); #1 frame_start = 1'b1;
      @(posedge c); #1 frame_start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         corner_valid = 1'b1;
         corner_x     = cx(i);
         corner_y     = cy(i);
         corner_score = cs(i);
         @(posedge c); #1;
         if (txs_write) begin
            seen = 1'b1;
            break;
         end
      end
      chk("g_burst_seen", seen, 1'b1);
      mon_en = 1'b0;
      corner_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge c); #1;
      chk("g_rst_write", txs_write, 1'b0);
      chk("g_rst_count", corner_count, 16'h0);
      rst_n = 1'b1;
      wr_mode = 0;
      exp_seq = 0;
      @(posedge c); #1;
      mon_en = 1'b1;

      // frame after reset: sequence number restarts at 0
      run_frame(8, 1000, 0, 0, -1);
      chk("h_count", corner_count, 16'd8);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
